split_solution_gen: RTL and testbench

- Candidate-assignment generator: the driving end of a split_N constraint checker.
- Produces pseudo-random packed variable vectors from an LFSR, presents each candidate on the checker's flattened inputs, samples the checker's x output, and returns the first satisfying assignment on a valid/ready stream.
- Sits between the solver's sampling controller and any split_N checker instance.

---
 rtl/split_solution_gen.sv | 130 +++++++++++++
 tb/tb_split_solution_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_solution_gen.sv
// rtl/split_solution_gen.sv - LFSR candidate generator driving a split_N checker, returns first satisfying assignment
module split_solution_gen #(
    parameter int          VEC_W     = 64,
    parameter int          MAX_TRIES = 1024,
    parameter logic [63:0] SEED_DEF  = 64'h0000_0000_0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [63:0]      seed_in,
    input  logic             start,
    output logic [VEC_W-1:0] cand,
    input  logic             chk_ok,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [VEC_W-1:0] sol_data,
    output logic             busy,
    output logic             fail,
    output logic [15:0]      tries
);

    // Number of 64-bit LFSR words needed to fill one candidate
    localparam int          NW        = (VEC_W + 63) / 64;
    localparam int          WCW       = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [63:0] TAP_MASK  = 64'hD800_0000_0000_0000;
    localparam logic [15:0] MAX_T16   = 16'(MAX_TRIES);
    localparam logic [WCW-1:0] LAST_W = WCW'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_CHECK = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [63:0]      r_lfsr;
    logic [VEC_W-1:0] r_cand;
    logic [VEC_W-1:0] r_sol_data;
    logic             r_sol_valid;
    logic             r_fail;
    logic [15:0]      r_tries;
    logic [WCW-1:0]   r_word;

    logic [63:0]      w_lfsr_next;
    logic [VEC_W-1:0] w_cand_next;
    logic [15:0]      w_tries_inc;

    // Galois right-shift step: the bit shifted out selects the tap mask
    assign w_lfsr_next = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? TAP_MASK : 64'h0);
    assign w_tries_inc = r_tries + 16'd1;

    // Each fresh word enters at the top of the candidate; older words slide down
    generate
        if (VEC_W <= 64) begin : g_narrow
            assign w_cand_next = w_lfsr_next[VEC_W-1:0];
        end else begin : g_wide
            assign w_cand_next = {w_lfsr_next, r_cand[VEC_W-1:64]};
        end
    endgenerate

    // Search FSM: generate candidate words, check, hold the solution until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED_DEF;
            r_cand      <= '0;
            r_sol_data  <= '0;
            r_sol_valid <= 1'b0;
            r_fail      <= 1'b0;
            r_tries     <= 16'd0;
            r_word      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= (seed_in == 64'h0) ? 64'h1 : seed_in;
                    end else if (start) begin
                        r_tries <= 16'd0;
                        r_fail  <= 1'b0;
                        r_word  <= '0;
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_lfsr <= w_lfsr_next;
                    r_cand <= w_cand_next;
                    if (r_word == LAST_W) begin
                        r_word  <= '0;
                        r_state <= S_CHECK;
                    end else begin
                        r_word <= r_word + WCW'(1);
                    end
                end
                S_CHECK: begin
                    if (chk_ok) begin
                        r_sol_data  <= r_cand;
                        r_sol_valid <= 1'b1;
                        r_tries     <= w_tries_inc;
                        r_state     <= S_HOLD;
                    end else if (w_tries_inc == MAX_T16) begin
                        r_tries <= MAX_T16;
                        r_fail  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tries <= w_tries_inc;
                        r_state <= S_GEN;
                    end
                end
                S_HOLD: begin
                    if (sol_ready) begin
                        r_sol_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cand      = r_cand;
    assign sol_data  = r_sol_data;
    assign sol_valid = r_sol_valid;
    assign busy      = (r_state != S_IDLE);
    assign fail      = r_fail;
    assign tries     = r_tries;

endmodule

// File: tb/tb_split_solution_gen.sv
// tb/tb_split_solution_gen.sv - randomized self-checking bench for split_solution_gen
module tb_split_solution_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 64-bit candidates, MAX_TRIES=6
    logic        rst_a, seed_load_a, start_a, chk_ok_a, sol_valid_a, sol_ready_a, busy_a, fail_a;
    logic [63:0] seed_in_a, cand_a, sol_data_a, tgt_a;
    logic [15:0] tries_a;

    // Instance B: 100-bit candidates (two words), MAX_TRIES=3
    logic         rst_b, seed_load_b, start_b, chk_ok_b, sol_valid_b, sol_ready_b, busy_b, fail_b;
    logic [63:0]  seed_in_b;
    logic [99:0]  cand_b, sol_data_b, tgt_b;
    logic [15:0]  tries_b;

    // Checker stand-in: accepts exactly one chosen candidate
    assign chk_ok_a = (cand_a == tgt_a);
    assign chk_ok_b = (cand_b == tgt_b);

    split_solution_gen #(.VEC_W(64), .MAX_TRIES(6), .SEED_DEF(64'h1)) u_a (
        .clk(clk), .rst(rst_a), .seed_load(seed_load_a), .seed_in(seed_in_a),
        .start(start_a), .cand(cand_a), .chk_ok(chk_ok_a), .sol_valid(sol_valid_a),
        .sol_ready(sol_ready_a), .sol_data(sol_data_a), .busy(busy_a),
        .fail(fail_a), .tries(tries_a)
    );

    split_solution_gen #(.VEC_W(100), .MAX_TRIES(3), .SEED_DEF(64'h1)) u_b (
        .clk(clk), .rst(rst_b), .seed_load(seed_load_b), .seed_in(seed_in_b),
        .start(start_b), .cand(cand_b), .chk_ok(chk_ok_b), .sol_valid(sol_valid_b),
        .sol_ready(sol_ready_b), .sol_data(sol_data_b), .busy(busy_b),
        .fail(fail_b), .tries(tries_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] m_lfsr_a, m_lfsr_b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR: multiply-by-x in the reflected polynomial domain
    function automatic logic [63:0] step(input logic [63:0] s);
        logic [63:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ 64'hD800_0000_0000_0000;
        return r;
    endfunction

    // Two-word candidate: second word on top, upper 36 bits of the first below it
    function automatic logic [99:0] gen100(input logic [63:0] s, output logic [63:0] s_out);
        logic [63:0]  s1, s2;
        logic [127:0] both;
        s1    = step(s);
        s2    = step(s1);
        both  = {s2, s1} >> 28;
        s_out = s2;
        return both[99:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic search_a(input int k, input string tag);
        logic [63:0] s;
        int cyc;
        s = m_lfsr_a;
        for (int i = 0; i < k; i++) s = step(s);
        tgt_a   = s;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, "_start_busy"}, 128'(busy_a), 128'(1));
        check({tag, "_start_fail"}, 128'(fail_a), 128'(0));
        check({tag, "_start_tries"}, 128'(tries_a), 128'(0));
        cyc = 0;
        while (!sol_valid_a && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(2 * k));
        check({tag, "_data"}, 128'(sol_data_a), 128'(s));
        check({tag, "_tries"}, 128'(tries_a), 128'(k));
        m_lfsr_a = s;
    endtask

    task automatic accept_a(input string tag);
        sol_ready_a = 1'b1;
        tick();
        sol_ready_a = 1'b0;
        check({tag, "_acc_valid"}, 128'(sol_valid_a), 128'(0));
        check({tag, "_acc_busy"}, 128'(busy_a), 128'(0));
    endtask

    task automatic search_b(input int k, input string tag);
        logic [63:0] s;
        logic [99:0] c;
        int cyc;
        s = m_lfsr_b;
        c = '0;
        for (int i = 0; i < k; i++) c = gen100(s, s);
        tgt_b   = c;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (!sol_valid_b && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(3 * k));
        check({tag, "_data"}, 128'(sol_data_b), 128'(c));
        check({tag, "_tries"}, 128'(tries_b), 128'(k));
        m_lfsr_b = s;
        sol_ready_b = 1'b1;
        tick();
        sol_ready_b = 1'b0;
        check({tag, "_acc_busy"}, 128'(busy_b), 128'(0));
    endtask

    initial begin
        logic [63:0] sd, hd, hc;
        logic [15:0] ht;
        int k, cyc;

        rst_a = 1'b1; seed_load_a = 1'b0; start_a = 1'b0; sol_ready_a = 1'b0; seed_in_a = '0; tgt_a = '0;
        rst_b = 1'b1; seed_load_b = 1'b0; start_b = 1'b0; sol_ready_b = 1'b0; seed_in_b = '0; tgt_b = '0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        m_lfsr_a = 64'h1;
        m_lfsr_b = 64'h1;

        check("rst_cand", 128'(cand_a), 128'(0));
        check("rst_sol_valid", 128'(sol_valid_a), 128'(0));
        check("rst_sol_data", 128'(sol_data_a), 128'(0));
        check("rst_busy", 128'(busy_a), 128'(0));
        check("rst_fail", 128'(fail_a), 128'(0));
        check("rst_tries", 128'(tries_a), 128'(0));
        check("rst_b_cand", 128'(cand_b), 128'(0));

        // Zero seed is replaced by 1; first candidate is the tap mask
        seed_load_a = 1'b1; seed_in_a = 64'h0;
        tick();
        seed_load_a = 1'b0;
        m_lfsr_a = 64'h1;
        search_a(1, "first");
        check("first_const", 128'(sol_data_a), 128'(64'hD800_0000_0000_0000));
        accept_a("first");

        search_a(5, "five");
        accept_a("five");

        // Randomized seeds and solution positions, including the last allowed try
        for (int it = 0; it < 6; it++) begin
            sd = {$urandom, $urandom};
            seed_load_a = 1'b1; seed_in_a = sd;
            tick();
            seed_load_a = 1'b0;
            m_lfsr_a = (sd == 64'h0) ? 64'h1 : sd;
            k = (it == 0) ? 6 : int'($urandom_range(1, 6));
            search_a(k, "rnd");
            if (it == 1) begin
                hd = sol_data_a; hc = cand_a; ht = tries_a;
                for (int i = 0; i < 10; i++) begin
                    start_a = (i % 2 == 0);
                    tick();
                    check("bp_valid", 128'(sol_valid_a), 128'(1));
                    check("bp_data", 128'(sol_data_a), 128'(hd));
                    check("bp_cand", 128'(cand_a), 128'(hc));
                    check("bp_tries", 128'(tries_a), 128'(ht));
                end
                start_a = 1'b0;
            end
            accept_a("rnd");
            if (it == 1) begin
                tick();
                check("bp_one_xfer", 128'(sol_valid_a), 128'(0));
            end
        end

        // Exhaust MAX_TRIES with a checker that never accepts
        tgt_a   = 64'h0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 200) begin
            tick();
            cyc++;
        end
        check("fail_latency", 128'(cyc), 128'(12));
        check("fail_flag", 128'(fail_a), 128'(1));
        check("fail_tries", 128'(tries_a), 128'(6));
        check("fail_valid", 128'(sol_valid_a), 128'(0));
        for (int i = 0; i < 6; i++) m_lfsr_a = step(m_lfsr_a);
        tick();
        check("fail_sticky", 128'(fail_a), 128'(1));
        search_a(2, "after_fail");
        accept_a("after_fail");

        // seed_load wins over start in the same cycle
        sd = {$urandom, $urandom} | 64'h1;
        seed_load_a = 1'b1; start_a = 1'b1; seed_in_a = sd;
        tick();
        seed_load_a = 1'b0; start_a = 1'b0;
        check("seedstart_busy", 128'(busy_a), 128'(0));
        m_lfsr_a = sd;
        search_a(2, "seedstart");
        accept_a("seedstart");

        // Reset during GEN
        tgt_a   = 64'h0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        rst_a   = 1'b1;
        tick();
        rst_a   = 1'b0;
        check("rstgen_busy", 128'(busy_a), 128'(0));
        check("rstgen_cand", 128'(cand_a), 128'(0));
        check("rstgen_data", 128'(sol_data_a), 128'(0));
        check("rstgen_tries", 128'(tries_a), 128'(0));
        m_lfsr_a = 64'h1;

        // Reset while holding a solution drops it
        search_a(3, "prehold");
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("rsthold_valid", 128'(sol_valid_a), 128'(0));
        check("rsthold_data", 128'(sol_data_a), 128'(0));
        check("rsthold_busy", 128'(busy_a), 128'(0));
        check("rsthold_tries", 128'(tries_a), 128'(0));
        m_lfsr_a = 64'h1;
        search_a(1, "postrst");
        check("postrst_const", 128'(sol_data_a), 128'(64'hD800_0000_0000_0000));
        accept_a("postrst");

        // Two-word candidates
        search_b(1, "b_first");
        check("b_lo_const", 128'(sol_data_b[35:0]), 128'(36'hD_8000_0000));
        check("b_hi_const", 128'(sol_data_b[99:36]), 128'(64'h6C00_0000_0000_0000));
        for (int it = 0; it < 3; it++) begin
            sd = {$urandom, $urandom};
            seed_load_b = 1'b1; seed_in_b = sd;
            tick();
            seed_load_b = 1'b0;
            m_lfsr_b = (sd == 64'h0) ? 64'h1 : sd;
            search_b(int'($urandom_range(1, 3)), "b_rnd");
        end
        tgt_b   = '0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 200) begin
            tick();
            cyc++;
        end
        check("b_fail_latency", 128'(cyc), 128'(9));
        check("b_fail_flag", 128'(fail_b), 128'(1));
        check("b_fail_tries", 128'(tries_b), 128'(3));
        for (int i = 0; i < 6; i++) m_lfsr_b = step(m_lfsr_b);
        search_b(2, "b_after_fail");
        check("b_after_fail_flag", 128'(fail_b), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
